// File: rtl/pkg_ram.sv
`default_nettype none
// ============================================================================
// Module      : pkg_ram
// Description : Shared RAM access sizes, store data types and the alignment
//               rule used by the quad store read-modify-write block.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_ram;

    localparam int RAM_BYTE_SIZE = 8;
    localparam int RAM_WORD_SIZE = 16;
    localparam int RAM_LONG_SIZE = 32;
    localparam int RAM_QUAD_SIZE = 64;

    typedef enum logic [1:0] {
        RAM_BYTE = 2'd0,
        RAM_WORD = 2'd1,
        RAM_LONG = 2'd2,
        RAM_QUAD = 2'd3
    } data_type_t;

    // A store is misaligned when its byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input data_type_t dtype, input logic [2:0] offset);
        logic mis;
        mis = 1'b0;
        case (dtype)
            RAM_WORD: mis = offset[0];
            RAM_LONG: mis = |offset[1:0];
            RAM_QUAD: mis = |offset;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : quad_lane_merge
// Description : Combinational big-endian lane insertion. Places the low
//               8/16/32/64 bits of value_i at byte offset offset_i of
//               old_quad_i (offset 0 = bits 63:56); other bytes pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_lane_merge
    import pkg_ram::*;
(
    input  logic [RAM_QUAD_SIZE-1:0] old_quad_i,
    input  logic [RAM_QUAD_SIZE-1:0] value_i,
    input  logic [2:0]               offset_i,
    input  data_type_t               dtype_i,
    output logic [RAM_QUAD_SIZE-1:0] merged_o
);

    logic [RAM_QUAD_SIZE-1:0] w_lane_mask;
    logic [RAM_QUAD_SIZE-1:0] w_field_mask;
    logic [6:0]               w_field_bits;
    logic [6:0]               w_shift;

    // Field of the store sits so that its last byte ends at offset+size-1:
    // left shift = 64 - 8*offset - field width.
    always_comb begin
        w_lane_mask  = {RAM_QUAD_SIZE{1'b1}};
        w_field_bits = 7'd64;
        case (dtype_i)
            RAM_BYTE: begin
                w_lane_mask  = 64'h0000_0000_0000_00FF;
                w_field_bits = 7'd8;
            end
            RAM_WORD: begin
                w_lane_mask  = 64'h0000_0000_0000_FFFF;
                w_field_bits = 7'd16;
            end
            RAM_LONG: begin
                w_lane_mask  = 64'h0000_0000_FFFF_FFFF;
                w_field_bits = 7'd32;
            end
            default: begin
                w_lane_mask  = {RAM_QUAD_SIZE{1'b1}};
                w_field_bits = 7'd64;
            end
        endcase
        w_shift      = 7'd64 - {1'b0, offset_i, 3'b000} - w_field_bits;
        w_field_mask = w_lane_mask << w_shift;
        merged_o     = (old_quad_i & ~w_field_mask) | ((value_i & w_lane_mask) << w_shift);
    end

endmodule
`default_nettype wire

// File: rtl/quad_store_rmw.sv
`default_nettype none
// ============================================================================
// Module      : quad_store_rmw
// Description : Sub-quad store engine. Byte/word/long stores read the
//               containing quad, merge the new lanes and write it back; quad
//               stores write directly; misaligned stores end in an error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_store_rmw
    import pkg_ram::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [RAM_QUAD_SIZE-1:0] req_data,
    input  data_type_t               req_type,
    output logic                     done,
    output logic                     err,
    output logic [ADDR_WIDTH-4:0]    ram_addr,
    output logic                     ram_re,
    input  logic [RAM_QUAD_SIZE-1:0] ram_rdata,
    output logic                     ram_we,
    output logic [RAM_QUAD_SIZE-1:0] ram_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                   state_q;
    logic [2:0]               offset_q;
    logic [RAM_QUAD_SIZE-1:0] data_q;
    data_type_t               type_q;
    logic [ADDR_WIDTH-4:0]    ram_addr_q;
    logic                     ram_re_q;
    logic                     ram_we_q;
    logic [RAM_QUAD_SIZE-1:0] ram_wdata_q;
    logic                     done_q;
    logic                     err_q;
    logic [RAM_QUAD_SIZE-1:0] merged_d;

    // Read data arrives in MERGE and is combined with the latched store value.
    quad_lane_merge u_lane_merge (
        .old_quad_i (ram_rdata),
        .value_i    (data_q),
        .offset_i   (offset_q),
        .dtype_i    (type_q),
        .merged_o   (merged_d)
    );

    assign req_ready = (state_q == S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_re    = ram_re_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

    // Request sequencer; strobes are registered so each is high for exactly
    // the state it belongs to, and async reset drops them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            offset_q    <= 3'd0;
            data_q      <= '0;
            type_q      <= RAM_BYTE;
            ram_addr_q  <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ram_re_q <= 1'b0;
            ram_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        offset_q   <= req_addr[2:0];
                        data_q     <= req_data;
                        type_q     <= req_type;
                        ram_addr_q <= req_addr[ADDR_WIDTH-1:3];
                        if (is_misaligned(req_type, req_addr[2:0])) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (req_type == RAM_QUAD) begin
                            state_q     <= S_WRITE;
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= req_data;
                            done_q      <= 1'b1;
                        end else begin
                            state_q  <= S_READ;
                            ram_re_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_MERGE;
                end
                S_MERGE: begin
                    state_q     <= S_WRITE;
                    ram_wdata_q <= merged_d;
                    ram_we_q    <= 1'b1;
                    done_q      <= 1'b1;
                end
                S_WRITE, S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
